// File: rtl/spi_pkg.sv
// Shared definitions for the SPI memory initiator: frame geometry and FSM state codes.
package spi_pkg;

  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int FRAME_W = 16;
  localparam logic RW_READ = 1'b1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LEAD  = 3'd1;
  localparam logic [2:0] HI    = 3'd2;
  localparam logic [2:0] LO    = 3'd3;
  localparam logic [2:0] TRAIL = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

endpackage

// File: rtl/spi_half_timer.sv
// Loadable down-counter; tc is high in the last cycle of every CLK_DIV-cycle phase.
module spi_half_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tc
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RELOAD;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator for one 16-bit frame: 7-bit address, rw bit, 8 data bits, MSB first.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              sclk_pin,
  output logic              cs_pin,
  output logic              mosi_pin,
  input  logic              miso_pin
);

  logic [2:0]         state;
  logic [2:0]         state_nx;
  logic [3:0]         bit_cnt;
  logic [FRAME_W-1:0] frame_sh;
  logic [DATA_W-1:0]  rx_sh;
  logic               rw_q;
  logic               tc;
  logic               load;
  logic               accept;
  logic               sample;

  // busy still high during the DONE output cycle blocks a re-accept there
  assign accept = (state == IDLE) && start && !busy;
  assign sample = (state == HI) && tc;
  assign load   = (state_nx != state);

  spi_half_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .tc    (tc)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = LEAD;
      LEAD:    if (tc) state_nx = HI;
      HI:      if (tc) state_nx = LO;
      LO:      if (tc) state_nx = (bit_cnt == 4'd15) ? TRAIL : HI;
      TRAIL:   if (tc) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
    end else begin
      state <= state_nx;
      if (accept) begin
        bit_cnt <= 4'd0;
      end else if ((state == LO) && tc) begin
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  // Shift data needs no reset: it is reloaded on every accepted start
  always_ff @(posedge clk) begin
    if (accept) begin
      frame_sh <= {addr, rw, (rw == RW_READ) ? {DATA_W{1'b0}} : wdata};
      rw_q     <= rw;
    end else if (sample) begin
      frame_sh <= {frame_sh[FRAME_W-2:0], 1'b0};
      rx_sh    <= {rx_sh[DATA_W-2:0], miso_pin};
    end
  end

  // Pins follow the current state one cycle later, so nothing from an input reaches a pin directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_pin   <= 1'b1;
      sclk_pin <= 1'b0;
      mosi_pin <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
    end else begin
      cs_pin   <= (state == IDLE) || (state == DONE);
      sclk_pin <= (state == HI);
      mosi_pin <= ((state == IDLE) || (state == DONE)) ? 1'b0 : frame_sh[FRAME_W-1];
      busy     <= (state != IDLE);
      done     <= (state == DONE);
      if ((state == DONE) && (rw_q == RW_READ)) begin
        rdata <= rx_sh;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three instances (CLK_DIV 2, 1, 255) observed through a selector.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] addr = '0;
  logic       rw = 1'b0;
  logic [7:0] wdata = '0;
  logic       miso = 1'b0;
  logic [1:0] sel = 2'd0;

  always #5 clk = ~clk;

  logic [7:0] rdata0, rdata1, rdata2;
  logic busy0, busy1, busy2, done0, done1, done2;
  logic sclk0, sclk1, sclk2, cs0, cs1, cs2, mosi0, mosi1, mosi2;

  spi_master #(.CLK_DIV(2)) u_div2 (
    .clk(clk), .rst_n(rst_n), .start(start && (sel == 2'd0)), .addr(addr), .rw(rw),
    .wdata(wdata), .rdata(rdata0), .busy(busy0), .done(done0), .sclk_pin(sclk0),
    .cs_pin(cs0), .mosi_pin(mosi0), .miso_pin(miso));
  spi_master #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .start(start && (sel == 2'd1)), .addr(addr), .rw(rw),
    .wdata(wdata), .rdata(rdata1), .busy(busy1), .done(done1), .sclk_pin(sclk1),
    .cs_pin(cs1), .mosi_pin(mosi1), .miso_pin(miso));
  spi_master #(.CLK_DIV(255)) u_div255 (
    .clk(clk), .rst_n(rst_n), .start(start && (sel == 2'd2)), .addr(addr), .rw(rw),
    .wdata(wdata), .rdata(rdata2), .busy(busy2), .done(done2), .sclk_pin(sclk2),
    .cs_pin(cs2), .mosi_pin(mosi2), .miso_pin(miso));

  logic [7:0] rdata_s;
  logic busy_s, done_s, sclk_s, cs_s, mosi_s;

  always_comb begin
    case (sel)
      2'd1:    begin rdata_s = rdata1; busy_s = busy1; done_s = done1; sclk_s = sclk1; cs_s = cs1; mosi_s = mosi1; end
      2'd2:    begin rdata_s = rdata2; busy_s = busy2; done_s = done2; sclk_s = sclk2; cs_s = cs2; mosi_s = mosi2; end
      default: begin rdata_s = rdata0; busy_s = busy0; done_s = done0; sclk_s = sclk0; cs_s = cs0; mosi_s = mosi0; end
    endcase
  end

  int tests_run = 0;
  int failed = 0;

  // Observations collected by watch()
  int k, nframes, done_cnt, done_k, first_rise_k;
  int hi_min, hi_max, lo_min, lo_max, gap_min;
  int last_rise_k, last_fall_k, cs_rise_k;
  int rises [2];
  logic [15:0] stream [2];
  logic [7:0]  rd_done [2];
  logic [7:0]  mem_byte [2];
  logic [7:0]  rd_model [3];
  bit timeout;

  function automatic logic [15:0] exp_frame(input logic [6:0] a, input logic r, input logic [7:0] w);
    return {a, r, r ? 8'h00 : w};
  endfunction

  task automatic begin_frame(input logic [6:0] a, input logic r, input logic [7:0] w);
    @(negedge clk);
    addr = a; rw = r; wdata = w; start = 1'b1;
  endtask

  // Memory model plus pin monitor; k counts clk edges since the accepting edge
  task automatic watch(input int budget, input int want_done, input int tail, input int abort_rises,
                       input bit hold, input int poke_k, input logic [6:0] p_addr,
                       input logic p_rw, input logic [7:0] p_wdata);
    int stop_k;
    int fi;
    bit run;
    logic sclk_q, cs_q;
    stop_k = -1; fi = 0; run = 1'b1;
    k = 0; nframes = 0; done_cnt = 0; done_k = -1; first_rise_k = -1;
    hi_min = 1 << 30; hi_max = 0; lo_min = 1 << 30; lo_max = 0; gap_min = 1 << 30;
    last_rise_k = -1; last_fall_k = -1; cs_rise_k = -1; timeout = 1'b0;
    for (int i = 0; i < 2; i++) begin rises[i] = 0; stream[i] = '0; rd_done[i] = '0; end
    miso = 1'b0;
    @(negedge clk);
    if (!hold) start = 1'b0;
    sclk_q = sclk_s; cs_q = cs_s;
    while (run) begin
      @(negedge clk);
      k++;
      if (k == poke_k) begin addr = p_addr; rw = p_rw; wdata = p_wdata; start = 1'b1; end
      else if (!hold) start = 1'b0;
      if (cs_q && !cs_s) begin
        nframes++;
        if (cs_rise_k >= 0 && (k - cs_rise_k) < gap_min) gap_min = k - cs_rise_k;
        last_rise_k = -1; last_fall_k = -1;
      end
      if (!cs_q && cs_s) cs_rise_k = k;
      fi = (nframes > 2) ? 1 : ((nframes > 0) ? nframes - 1 : 0);
      if (!sclk_q && sclk_s) begin
        rises[fi]++;
        stream[fi] = {stream[fi][14:0], mosi_s};
        if (first_rise_k < 0) first_rise_k = k;
        if (last_fall_k >= 0) begin
          if (k - last_fall_k < lo_min) lo_min = k - last_fall_k;
          if (k - last_fall_k > lo_max) lo_max = k - last_fall_k;
        end
        last_rise_k = k;
      end
      if (sclk_q && !sclk_s) begin
        if (last_rise_k >= 0) begin
          if (k - last_rise_k < hi_min) hi_min = k - last_rise_k;
          if (k - last_rise_k > hi_max) hi_max = k - last_rise_k;
        end
        last_fall_k = k;
        miso = (rises[fi] >= 8 && rises[fi] <= 15) ? mem_byte[fi][15 - rises[fi]] : 1'b0;
      end
      if (done_s) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
        rd_done[fi] = rdata_s;
        if (done_cnt == want_done) begin stop_k = k + tail; start = 1'b0; end
      end
      sclk_q = sclk_s; cs_q = cs_s;
      if (abort_rises > 0 && rises[0] == abort_rises) run = 1'b0;
      if (stop_k >= 0 && k >= stop_k) run = 1'b0;
      if (k >= budget) begin timeout = 1'b1; run = 1'b0; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (cs_s !== 1'b1) begin failed++; $display("FAIL reset_cs got %b want 1", cs_s); end
    tests_run++; if (sclk_s !== 1'b0) begin failed++; $display("FAIL reset_sclk got %b want 0", sclk_s); end
    tests_run++; if (mosi_s !== 1'b0) begin failed++; $display("FAIL reset_mosi got %b want 0", mosi_s); end
    tests_run++; if (busy_s !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", busy_s); end
    tests_run++; if (done_s !== 1'b0) begin failed++; $display("FAIL reset_done got %b want 0", done_s); end
    tests_run++; if (rdata_s !== 8'h00) begin failed++; $display("FAIL reset_rdata got %h want 00", rdata_s); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) rd_model[i] = 8'h00;
  endtask

  task automatic test_write();
    sel = 2'd0; mem_byte[0] = 8'hFF;
    begin_frame(7'h15, 1'b0, 8'h5A);
    watch(300, 1, 5, 0, 1'b0, -1, '0, 1'b0, '0);
    tests_run++; if (timeout) begin failed++; $display("FAIL write_timeout got k=%0d want done", k); end
    tests_run++; if (stream[0] !== 16'h2A5A) begin failed++; $display("FAIL write_stream got %h want 2a5a", stream[0]); end
    tests_run++; if (rises[0] !== 16) begin failed++; $display("FAIL write_rises got %0d want 16", rises[0]); end
    tests_run++; if (done_k !== 69) begin failed++; $display("FAIL write_done_cycle got %0d want 69", done_k); end
    tests_run++; if (first_rise_k !== 3) begin failed++; $display("FAIL write_first_rise got %0d want 3", first_rise_k); end
    tests_run++; if (hi_min !== 2 || hi_max !== 2) begin failed++; $display("FAIL write_high got %0d..%0d want 2", hi_min, hi_max); end
    tests_run++; if (lo_min !== 2 || lo_max !== 2) begin failed++; $display("FAIL write_low got %0d..%0d want 2", lo_min, lo_max); end
    tests_run++; if (rd_done[0] !== 8'h00 || rdata_s !== 8'h00) begin failed++; $display("FAIL write_rdata got %h/%h want 00", rd_done[0], rdata_s); end
  endtask

  task automatic test_read();
    sel = 2'd0; mem_byte[0] = 8'hA5;
    begin_frame(7'h15, 1'b1, 8'h33);
    watch(300, 1, 5, 0, 1'b0, -1, '0, 1'b0, '0);
    rd_model[0] = 8'hA5;
    tests_run++; if (stream[0] !== 16'h2B00) begin failed++; $display("FAIL read_stream got %h want 2b00", stream[0]); end
    tests_run++; if (rd_done[0] !== 8'hA5) begin failed++; $display("FAIL read_rdata_done got %h want a5", rd_done[0]); end
    tests_run++; if (done_cnt !== 1) begin failed++; $display("FAIL read_done_count got %0d want 1", done_cnt); end
    repeat (10) @(negedge clk);
    tests_run++; if (rdata_s !== 8'hA5) begin failed++; $display("FAIL read_rdata_held got %h want a5", rdata_s); end
  endtask

  task automatic test_random_frames();
    logic [6:0] a; logic r; logic [7:0] w;
    sel = 2'd0;
    for (int n = 0; n < 4; n++) begin
      a = 7'($urandom); r = 1'($urandom); w = 8'($urandom); mem_byte[0] = 8'($urandom);
      begin_frame(a, r, w);
      watch(300, 1, 5, 0, 1'b0, -1, '0, 1'b0, '0);
      if (r) rd_model[0] = mem_byte[0];
      tests_run++; if (stream[0] !== exp_frame(a, r, w)) begin failed++; $display("FAIL rand_stream[%0d] got %h want %h", n, stream[0], exp_frame(a, r, w)); end
      tests_run++; if (rises[0] !== 16 || done_k !== 69) begin failed++; $display("FAIL rand_shape[%0d] got %0d rises done@%0d want 16 done@69", n, rises[0], done_k); end
      tests_run++; if (rdata_s !== rd_model[0]) begin failed++; $display("FAIL rand_rdata[%0d] got %h want %h", n, rdata_s, rd_model[0]); end
    end
  endtask

  task automatic test_busy_reject();
    logic [6:0] a; logic [7:0] w;
    sel = 2'd0; a = 7'($urandom); w = 8'($urandom); mem_byte[0] = 8'($urandom);
    begin_frame(a, 1'b0, w);
    watch(300, 1, 20, 0, 1'b0, 10, ~a, 1'b1, ~w);
    tests_run++; if (stream[0] !== exp_frame(a, 1'b0, w)) begin failed++; $display("FAIL busy_stream got %h want %h", stream[0], exp_frame(a, 1'b0, w)); end
    tests_run++; if (done_cnt !== 1) begin failed++; $display("FAIL busy_done_count got %0d want 1", done_cnt); end
    tests_run++; if (nframes !== 1) begin failed++; $display("FAIL busy_frames got %0d want 1", nframes); end
    tests_run++; if (rdata_s !== rd_model[0]) begin failed++; $display("FAIL busy_rdata got %h want %h", rdata_s, rd_model[0]); end
  endtask

  task automatic test_reset_midframe();
    logic [6:0] a; logic [7:0] w;
    sel = 2'd0; mem_byte[0] = 8'h3C;
    begin_frame(7'h2E, 1'b1, 8'h00);
    watch(300, 1, 5, 0, 1'b0, -1, '0, 1'b0, '0);
    tests_run++; if (rdata_s !== 8'h3C) begin failed++; $display("FAIL mid_pre_rdata got %h want 3c", rdata_s); end
    begin_frame(7'h55, 1'b0, 8'hC3);
    watch(300, 1, 5, 5, 1'b0, -1, '0, 1'b0, '0);
    rst_n = 1'b0;
    #1;
    tests_run++; if (cs_s !== 1'b1 || sclk_s !== 1'b0) begin failed++; $display("FAIL mid_pins got cs=%b sclk=%b want cs=1 sclk=0", cs_s, sclk_s); end
    tests_run++; if (busy_s !== 1'b0 || done_s !== 1'b0) begin failed++; $display("FAIL mid_busy got busy=%b done=%b want 0 0", busy_s, done_s); end
    tests_run++; if (rdata_s !== 8'h00) begin failed++; $display("FAIL mid_rdata got %h want 00", rdata_s); end
    for (int i = 0; i < 3; i++) rd_model[i] = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    a = 7'($urandom); w = 8'($urandom);
    begin_frame(a, 1'b0, w);
    watch(300, 1, 5, 0, 1'b0, -1, '0, 1'b0, '0);
    tests_run++; if (rises[0] !== 16 || stream[0] !== exp_frame(a, 1'b0, w)) begin failed++; $display("FAIL mid_clean got %0d rises %h want 16 %h", rises[0], stream[0], exp_frame(a, 1'b0, w)); end
    tests_run++; if (done_k !== 69) begin failed++; $display("FAIL mid_clean_done got %0d want 69", done_k); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] a0, a1; logic r0, r1; logic [7:0] w0, w1; logic [7:0] rd_exp;
    sel = 2'd1;
    a0 = 7'($urandom); r0 = 1'($urandom); w0 = 8'($urandom);
    a1 = 7'($urandom); r1 = 1'b1; w1 = 8'($urandom);
    mem_byte[0] = 8'($urandom); mem_byte[1] = 8'($urandom);
    begin_frame(a0, r0, w0);
    watch(300, 2, 5, 0, 1'b1, 5, a1, r1, w1);
    rd_exp = mem_byte[1];
    tests_run++; if (nframes !== 2 || done_cnt !== 2) begin failed++; $display("FAIL b2b_frames got %0d frames %0d dones want 2 2", nframes, done_cnt); end
    tests_run++; if (rises[0] !== 16 || rises[1] !== 16) begin failed++; $display("FAIL b2b_rises got %0d/%0d want 16/16", rises[0], rises[1]); end
    tests_run++; if (stream[0] !== exp_frame(a0, r0, w0)) begin failed++; $display("FAIL b2b_stream0 got %h want %h", stream[0], exp_frame(a0, r0, w0)); end
    tests_run++; if (stream[1] !== exp_frame(a1, r1, w1)) begin failed++; $display("FAIL b2b_stream1 got %h want %h", stream[1], exp_frame(a1, r1, w1)); end
    tests_run++; if (gap_min < 1 || gap_min > 100) begin failed++; $display("FAIL b2b_cs_gap got %0d want >=1", gap_min); end
    tests_run++; if (done_k !== 35) begin failed++; $display("FAIL b2b_done_cycle got %0d want 35", done_k); end
    tests_run++; if (hi_min !== 1 || lo_max !== 1) begin failed++; $display("FAIL b2b_phase got hi=%0d lo=%0d want 1 1", hi_min, lo_max); end
    tests_run++; if (rd_done[1] !== rd_exp || rdata_s !== rd_exp) begin failed++; $display("FAIL b2b_rdata got %h/%h want %h", rd_done[1], rdata_s, rd_exp); end
    rd_model[1] = rd_exp;
  endtask

  task automatic test_timing_255();
    logic [6:0] a; logic [7:0] w;
    sel = 2'd2; a = 7'($urandom); w = 8'($urandom); mem_byte[0] = 8'($urandom);
    begin_frame(a, 1'b1, w);
    watch(9000, 1, 5, 0, 1'b0, -1, '0, 1'b0, '0);
    tests_run++; if (hi_min !== 255 || hi_max !== 255) begin failed++; $display("FAIL t255_high got %0d..%0d want 255", hi_min, hi_max); end
    tests_run++; if (lo_min !== 255 || lo_max !== 255) begin failed++; $display("FAIL t255_low got %0d..%0d want 255", lo_min, lo_max); end
    tests_run++; if (done_k !== 8671) begin failed++; $display("FAIL t255_done_cycle got %0d want 8671", done_k); end
    tests_run++; if (rises[0] !== 16 || stream[0] !== exp_frame(a, 1'b1, w)) begin failed++; $display("FAIL t255_frame got %0d %h want 16 %h", rises[0], stream[0], exp_frame(a, 1'b1, w)); end
    tests_run++; if (rd_done[0] !== mem_byte[0]) begin failed++; $display("FAIL t255_rdata got %h want %h", rd_done[0], mem_byte[0]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_random_frames();
    test_busy_reject();
    test_reset_midframe();
    test_back_to_back();
    test_timing_255();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Synchronous SPI initiator that drives the serial side of our SPI memory: it generates the chip select, the serial clock and the master-out data line for one 16-bit frame, and captures the master-in data line. A frame is a 7-bit address, a read/write bit and 8 data bits. The block sits in the test harness or host FPGA and talks to the memory board over GPIO. The host side is a single-cycle start plus a done pulse.

## Interface
- CLK_DIV, default 2: length of each SCLK half-period in `clk` cycles; legal range 1..255.
- clk, input, 1: system clock; all logic on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle request; sampled only in IDLE.
- addr, input, 7: memory address; latched on accepted start.
- rw, input, 1: 1 = read, 0 = write; latched on accepted start.
- wdata, input, 8: write data; latched on accepted start; ignored for reads.
- rdata, output, 8: read data; updated only at done of a read frame; held otherwise.
- busy, output, 1: high from the cycle after an accepted start through the done cycle.
- done, output, 1: one-cycle pulse at frame end.
- sclk_pin, output, 1: serial clock; idles low (SPI mode 0).
- cs_pin, output, 1: chip select, active low; idles high.
- mosi_pin, output, 1: serial data to the memory, MSB first.
- miso_pin, input, 1: serial data from the memory.

## Operation
- Frame bit order on mosi_pin: addr[6..0], then rw, then wdata[7..0], for 16 bits MSB-first in a shift register. Read frames shift zeros in the data field.
- FSM states:
  - IDLE: cs_pin=1, sclk_pin=0, busy=0. When start=1, latch the frame, load the 16-bit shift register, clear the bit counter, and go to LEAD.
  - LEAD: cs_pin=0, mosi_pin=bit 15. Lasts CLK_DIV cycles, then go to HI.
  - HI: sclk_pin=1; the memory samples mosi_pin here. In the last cycle of HI, shift miso_pin into the receive register. Then go to LO.
  - LO: sclk_pin=0. In the first cycle of LO, mosi_pin shows the next bit. After the LO that ends bit 15, go to TRAIL; otherwise go to HI.
  - TRAIL: cs_pin=0, sclk_pin=0 for CLK_DIV cycles. Then go to DONE.
  - DONE: one cycle. cs_pin=1, done=1, busy=1. rdata gets receive[7:0] if rw=1. Then go to IDLE.
- Only the last 8 miso_pin samples, taken during the data field, are kept. Earlier samples shift out of an 8-bit receive register.
- All pin outputs are registered, with no combinational path from inputs to pins.
- Half-period counter width is clog2(CLK_DIV+1). The bit counter is 4 bits and wraps 15→0 only by leaving to TRAIL.

## Timing
- Reset values: cs_pin=1, sclk_pin=0, mosi_pin=0, busy=0, done=0, rdata=0x00; FSM goes to IDLE. Reset takes effect asynchronously, including mid-frame. The pins return to idle immediately and the partial frame is discarded.
- start accepted at edge 0. cs_pin falls at edge 1. The first sclk_pin rise comes CLK_DIV cycles later.
- Exactly 16 sclk_pin pulses per frame. Each pulse is high for CLK_DIV cycles and low for CLK_DIV cycles.
- done is asserted at edge 1 + 34·CLK_DIV (69 for CLK_DIV=2), in the same cycle cs_pin returns high.
- start while busy=1, including during the DONE cycle, is ignored with no queuing.
- The earliest next accept is the cycle after DONE, so cs_pin is high for at least 1 cycle between frames.
- With CLK_DIV=1, sample and shift happen in adjacent cycles; the behaviour above still holds.
- miso_pin is sampled directly at the end of HI, with no synchronizer. The memory changes miso_pin only after the sclk_pin falling edge.

## Structure
- Shared package spi_pkg holds the state enum (IDLE, LEAD, HI, LO, TRAIL, DONE) and the constants ADDR_W=7, DATA_W=8, FRAME_W=16, RW_READ=1.
- One sub-module, spi_half_timer, is the loadable down-counter that produces a terminal-count pulse every CLK_DIV cycles. It is reused for LEAD, HI, LO and TRAIL.
- The FSM, shift registers and pin registers live in spi_master.

## Test plan
- Write frame: addr=0x15, rw=0, wdata=0x5A, CLK_DIV=2. Required: the mosi_pin stream captured on sclk_pin rising edges is 0x2A5A; exactly 16 rises; done at cycle 69; rdata stays 0x00.
- Read frame: addr=0x15, rw=1, and the memory model drives 0xA5 on miso_pin after each sclk_pin falling edge in the data field. Required: mosi_pin stream is 0x2B00; rdata=0xA5 in the done cycle and held afterwards.
- Busy rejection: pulse start again at cycle 10 of a frame with different addr. Required: the frame is unaffected, there is one done pulse, and no second frame.
- Reset mid-frame: assert rst_n=0 after the 5th sclk_pin rise. Required: cs_pin=1 and sclk_pin=0 immediately, busy=0, rdata=0x00. The next start yields a clean 16-pulse frame.
- Back-to-back with CLK_DIV=1: two frames with start held high. Required: each frame has 16 pulses; cs_pin is high for at least 1 cycle between frames; the second frame uses the inputs latched at its own accept.
- Timing check at CLK_DIV=255: sclk_pin high and low phases are each 255 cycles; done at cycle 1 + 34·255 = 8671.
